// File: rtl/axis_histogram_accumulator_if.sv
// Bus bundle between the histogram accumulator and its event source / readout controller.
interface axis_histogram_accumulator_if;
    logic        acq_enable;
    logic        event_valid;
    logic [6:0]  event_x;
    logic [6:0]  event_y;
    logic [6:0]  read_index_yaxis;
    logic [6:0]  read_index_xaxis;
    logic [15:0] data_yaxis;
    logic [15:0] data_xaxis;
    logic        start_sending;
    logic [15:0] frame_count;
    logic [15:0] dropped_events;

    modport master (
        output acq_enable, event_valid, event_x, event_y,
        output read_index_yaxis, read_index_xaxis,
        input  data_yaxis, data_xaxis, start_sending, frame_count, dropped_events
    );

    modport slave (
        input  acq_enable, event_valid, event_x, event_y,
        input  read_index_yaxis, read_index_xaxis,
        output data_yaxis, data_xaxis, start_sending, frame_count, dropped_events
    );
endinterface

// File: rtl/axis_histogram_accumulator.sv
// Accumulates X/Y hit positions into two 128-bin projection histograms per frame,
// then freezes them for a fixed readout hold window before clearing.
module axis_histogram_accumulator #(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES  = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    axis_histogram_accumulator_if.slave  bus
);

    localparam int unsigned FW = $clog2(FRAME_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_READOUT,
        S_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            start_q;
    logic [15:0]     frames_q;
    logic [15:0]     dropped_q;
    logic [15:0]     bins_y_q [128];
    logic [15:0]     bins_x_q [128];

    logic            accept;
    logic            drop;
    logic [15:0]     y_cur, x_cur;
    logic [15:0]     y_inc, x_inc;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.acq_enable) begin
                    state_d     = S_ACCUM;
                    frame_cnt_d = '0;
                end
            end
            S_ACCUM: begin
                if (frame_cnt_q == FRAME_LAST || !bus.acq_enable) begin
                    state_d    = S_READOUT;
                    hold_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            S_READOUT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_CLEAR;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                state_d     = bus.acq_enable ? S_ACCUM : S_IDLE;
                frame_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept = bus.event_valid && (state_q == S_ACCUM);
        drop   = bus.event_valid && (state_q != S_ACCUM);
        y_cur  = bins_y_q[bus.event_y];
        x_cur  = bins_x_q[bus.event_x];
        y_inc  = (y_cur == 16'hFFFF) ? y_cur : y_cur + 16'd1;
        x_inc  = (x_cur == 16'hFFFF) ? x_cur : x_cur + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            start_q     <= 1'b0;
            frames_q    <= '0;
            dropped_q   <= '0;
            for (int unsigned i = 0; i < 128; i++) begin
                bins_y_q[i[6:0]] <= '0;
                bins_x_q[i[6:0]] <= '0;
            end
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            start_q     <= (state_d == S_READOUT);
            if (state_q == S_CLEAR) begin
                frames_q <= frames_q + 16'd1;
            end
            if (drop && dropped_q != 16'hFFFF) begin
                dropped_q <= dropped_q + 16'd1;
            end
            // Bins are wiped on the edge into CLEAR so they already read zero while CLEAR is active.
            if (state_d == S_CLEAR) begin
                for (int unsigned i = 0; i < 128; i++) begin
                    bins_y_q[i[6:0]] <= '0;
                    bins_x_q[i[6:0]] <= '0;
                end
            end else if (accept) begin
                bins_y_q[bus.event_y] <= y_inc;
                bins_x_q[bus.event_x] <= x_inc;
            end
        end
    end

    assign bus.data_yaxis     = bins_y_q[bus.read_index_yaxis];
    assign bus.data_xaxis     = bins_x_q[bus.read_index_xaxis];
    assign bus.start_sending  = start_q;
    assign bus.frame_count    = frames_q;
    assign bus.dropped_events = dropped_q;

endmodule

// File: tb/tb_axis_histogram_accumulator.sv
// Directed bench: short-frame instance for framing/freeze/drop/reset, long-frame instance for saturation.
module tb_axis_histogram_accumulator;

    logic clk = 1'b0;
    logic reset;
    always #500 clk = ~clk;

    axis_histogram_accumulator_if u_if ();
    axis_histogram_accumulator_if s_if ();

    axis_histogram_accumulator #(.FRAME_CYCLES(16), .HOLD_CYCLES(140)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    axis_histogram_accumulator #(.FRAME_CYCLES(70000), .HOLD_CYCLES(130)) s_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int hi;
    logic [15:0] exp_x [128];
    logic [15:0] exp_y [128];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 128; i++) begin
            exp_x[i] = 16'd0;
            exp_y[i] = 16'd0;
        end
    endtask

    task automatic chk_bins(input string tag);
        for (int i = 0; i < 128; i++) begin
            u_if.read_index_xaxis = 7'(i);
            u_if.read_index_yaxis = 7'(i);
            #1;
            chk($sformatf("%s x[%0d]", tag, i), {16'd0, u_if.data_xaxis}, {16'd0, exp_x[i]});
            chk($sformatf("%s y[%0d]", tag, i), {16'd0, u_if.data_yaxis}, {16'd0, exp_y[i]});
        end
    endtask

    task automatic ev(input logic v, input int unsigned x, input int unsigned y);
        u_if.event_valid = v;
        u_if.event_x     = 7'(x);
        u_if.event_y     = 7'(y);
    endtask

    initial begin
        reset = 1'b1;
        u_if.acq_enable = 1'b0;
        ev(1'b0, 0, 0);
        u_if.read_index_xaxis = '0;
        u_if.read_index_yaxis = '0;
        s_if.acq_enable = 1'b0;
        s_if.event_valid = 1'b0;
        s_if.event_x = '0;
        s_if.event_y = '0;
        s_if.read_index_xaxis = '0;
        s_if.read_index_yaxis = '0;
        clear_exp();

        tick();
        tick();
        chk("rst start_sending", {31'd0, u_if.start_sending}, 32'd0);
        chk("rst frame_count", {16'd0, u_if.frame_count}, 32'd0);
        chk("rst dropped", {16'd0, u_if.dropped_events}, 32'd0);
        chk_bins("rst");

        reset = 1'b0;
        repeat (50) tick();
        chk("idle start_sending", {31'd0, u_if.start_sending}, 32'd0);
        chk("idle frame_count", {16'd0, u_if.frame_count}, 32'd0);
        chk("idle dropped", {16'd0, u_if.dropped_events}, 32'd0);
        chk_bins("idle");

        // Basic frame: enter ACCUMULATE, four events
        u_if.acq_enable = 1'b1;
        tick();
        repeat (3) begin
            ev(1'b1, 5, 100);
            tick();
        end
        ev(1'b1, 127, 0);
        tick();
        ev(1'b0, 0, 0);
        exp_x[5] = 16'd3; exp_y[100] = 16'd3;
        exp_x[127] = 16'd1; exp_y[0] = 16'd1;
        chk("accum start_sending", {31'd0, u_if.start_sending}, 32'd0);
        repeat (11) tick();
        chk("pre-rise start_sending", {31'd0, u_if.start_sending}, 32'd0);
        tick();
        chk("rise start_sending", {31'd0, u_if.start_sending}, 32'd1);
        chk_bins("frame1");

        // Freeze/drop: events every cycle through READOUT and CLEAR
        ev(1'b1, 5, 100);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (u_if.start_sending !== 1'b1) break;
            hi++;
            u_if.read_index_xaxis = 7'd5;
            u_if.read_index_yaxis = 7'd100;
            #1;
            chk("frozen x[5]", {16'd0, u_if.data_xaxis}, 32'd3);
            chk("frozen y[100]", {16'd0, u_if.data_yaxis}, 32'd3);
            tick();
        end
        chk("hold length", hi, 32'd140);
        chk("clear start_sending", {31'd0, u_if.start_sending}, 32'd0);
        tick();
        ev(1'b0, 0, 0);
        chk("dropped after frame1", {16'd0, u_if.dropped_events}, 32'd141);
        chk("frame_count after frame1", {16'd0, u_if.frame_count}, 32'd1);
        clear_exp();
        chk_bins("cleared");

        // Early stop: two events, acq_enable drops in the 5th ACCUMULATE cycle
        ev(1'b1, 10, 20);
        tick();
        ev(1'b1, 10, 21);
        tick();
        ev(1'b0, 0, 0);
        tick();
        tick();
        u_if.acq_enable = 1'b0;
        chk("pre-stop start_sending", {31'd0, u_if.start_sending}, 32'd0);
        tick();
        chk("early readout start_sending", {31'd0, u_if.start_sending}, 32'd1);
        exp_x[10] = 16'd2; exp_y[20] = 16'd1; exp_y[21] = 16'd1;
        chk_bins("early");
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (u_if.start_sending !== 1'b1) break;
            hi++;
            tick();
        end
        chk("early hold length", hi, 32'd140);
        tick();
        chk("post-early start_sending", {31'd0, u_if.start_sending}, 32'd0);
        chk("frame_count after early", {16'd0, u_if.frame_count}, 32'd2);
        clear_exp();
        chk_bins("post-early");
        ev(1'b1, 3, 3);
        tick();
        ev(1'b0, 0, 0);
        chk("idle drop", {16'd0, u_if.dropped_events}, 32'd142);
        u_if.read_index_xaxis = 7'd3;
        u_if.read_index_yaxis = 7'd3;
        #1;
        chk("idle no accum x[3]", {16'd0, u_if.data_xaxis}, 32'd0);
        chk("idle no accum y[3]", {16'd0, u_if.data_yaxis}, 32'd0);
        repeat (5) tick();
        chk("stays idle start_sending", {31'd0, u_if.start_sending}, 32'd0);

        // Reset at hold cycle 50
        u_if.acq_enable = 1'b1;
        tick();
        ev(1'b1, 1, 2);
        tick();
        ev(1'b0, 0, 0);
        repeat (15) tick();
        chk("r readout start_sending", {31'd0, u_if.start_sending}, 32'd1);
        repeat (50) tick();
        u_if.read_index_xaxis = 7'd1;
        u_if.read_index_yaxis = 7'd2;
        #1;
        chk("pre-reset x[1]", {16'd0, u_if.data_xaxis}, 32'd1);
        chk("pre-reset y[2]", {16'd0, u_if.data_yaxis}, 32'd1);
        chk("pre-reset start_sending", {31'd0, u_if.start_sending}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid-reset start_sending", {31'd0, u_if.start_sending}, 32'd0);
        chk("mid-reset frame_count", {16'd0, u_if.frame_count}, 32'd0);
        chk("mid-reset dropped", {16'd0, u_if.dropped_events}, 32'd0);
        clear_exp();
        chk_bins("mid-reset");
        u_if.acq_enable = 1'b0;
        reset = 1'b0;

        // Saturation on the long-frame instance
        s_if.acq_enable = 1'b1;
        tick();
        s_if.event_valid = 1'b1;
        repeat (65534) tick();
        #1;
        chk("sat x[0] 65534", {16'd0, s_if.data_xaxis}, 32'hFFFE);
        chk("sat y[0] 65534", {16'd0, s_if.data_yaxis}, 32'hFFFE);
        tick();
        chk("sat x[0] 65535", {16'd0, s_if.data_xaxis}, 32'hFFFF);
        repeat (4464) tick();
        chk("sat pre-rise start_sending", {31'd0, s_if.start_sending}, 32'd0);
        tick();
        s_if.event_valid = 1'b0;
        s_if.acq_enable = 1'b0;
        chk("sat rise start_sending", {31'd0, s_if.start_sending}, 32'd1);
        chk("sat x[0] final", {16'd0, s_if.data_xaxis}, 32'hFFFF);
        chk("sat y[0] final", {16'd0, s_if.data_yaxis}, 32'hFFFF);
        chk("sat dropped", {16'd0, s_if.dropped_events}, 32'd0);
        s_if.read_index_xaxis = 7'd1;
        s_if.read_index_yaxis = 7'd1;
        #1;
        chk("sat x[1]", {16'd0, s_if.data_xaxis}, 32'd0);
        chk("sat y[1]", {16'd0, s_if.data_yaxis}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
